// File: rtl/sb_pkg.sv
// Shared sideband receive definitions: framing bytes, CRC-16 constants and byte update, FSM state types.
package sb_pkg;

    localparam int          SB_SYM_BITS  = 10;
    localparam logic [7:0]  SB_DLE       = 8'hFE;
    localparam logic [7:0]  SB_ETX       = 8'h40;
    localparam logic [15:0] SB_CRC_POLY  = 16'h8005;
    localparam logic [15:0] SB_CRC_SEED  = 16'hFFFF;

    typedef enum logic [1:0] {
        F_IDLE,
        F_WAIT_STX,
        F_DATA,
        F_ESC
    } frame_state_t;

    typedef enum logic [2:0] {
        S_HUNT,
        S_SHIFT,
        S_STOP,
        S_WAIT_HIGH,
        S_BREAK
    } sym_state_t;

    // MSB-first CRC-16 update over one byte, no reflection.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (c[15])
                c = {c[14:0], 1'b0} ^ SB_CRC_POLY;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/sb_symbol_rx.sv
// Recovers 10-bit start/data/stop symbols from sbrx; with SB_RX_DISCONNECT_DET_EN an all-zero
// symbol with a low stop bit is held as a possible line break until sbrx returns high.
module sb_symbol_rx
    import sb_pkg::*;
(
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       sbrx,
    input  logic       hunt_en,
    output logic [7:0] sym_byte,
    output logic       sym_valid,
    output logic       sym_err
);

`ifdef SB_RX_DISCONNECT_DET_EN
    localparam bit DEFER_BREAK = 1'b1;
`else
    localparam bit DEFER_BREAK = 1'b0;
`endif

    localparam int DATA_BITS = SB_SYM_BITS - 2;

    sym_state_t state;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       is_break;

    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            state   <= S_HUNT;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
        end else if (!hunt_en) begin
            state   <= S_HUNT;
            bit_cnt <= 3'd0;
        end else begin
            case (state)
                S_HUNT: begin
                    if (!sbrx) begin
                        state   <= S_SHIFT;
                        bit_cnt <= 3'd0;
                    end
                end
                S_SHIFT: begin
                    shreg   <= {sbrx, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'(DATA_BITS - 1))
                        state <= S_STOP;
                end
                S_STOP: begin
                    if (sbrx)
                        state <= S_HUNT;
                    else if (is_break)
                        state <= S_BREAK;
                    else
                        state <= S_WAIT_HIGH;
                end
                S_WAIT_HIGH, S_BREAK: begin
                    if (sbrx)
                        state <= S_HUNT;
                end
                default: state <= S_HUNT;
            endcase
        end
    end

    // Strobes are decoded from the stop-bit cycle so the framer registers them on that same edge.
    assign is_break  = DEFER_BREAK && (shreg == 8'h00);
    assign sym_byte  = shreg;
    assign sym_valid = hunt_en && (state == S_STOP) && sbrx;
    assign sym_err   = hunt_en && (((state == S_STOP) && !sbrx && !is_break) ||
                                   ((state == S_BREAK) && sbrx));

endmodule

// File: rtl/sb_rx_framer.sv
// Sideband receive framer: DLE/STX/ETX de-framing, destuffing, CRC-16 residue check and payload holdback.
// Optional line-disconnect detection is enabled with SB_RX_DISCONNECT_DET_EN.
module sb_rx_framer
    import sb_pkg::*;
#(
    parameter int          MAX_BYTES   = 32,
    parameter int          DISC_CYCLES = 1024,
    parameter logic [15:0] CRC_SEED    = SB_CRC_SEED
) (
    input  logic       sb_clk,
    input  logic       rst,
    input  logic       sbrx,
    input  logic       enable,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_first,
    output logic       rx_last,
    output logic [7:0] rx_stx,
    output logic       frame_done,
    output logic       crc_err,
    output logic       frame_err,
    output logic       disconnect
);

    localparam int EW = $clog2(MAX_BYTES + 1);

    logic         hunt_en;
    logic         disc_hold;
    logic [7:0]   sym_byte;
    logic         sym_valid;
    logic         sym_err;
    logic         data_take;

    frame_state_t state;
    logic [15:0]  crc;
    logic [7:0]   buf0, buf1, buf2;
    logic [1:0]   buf_cnt;
    logic [EW-1:0] emit_cnt;

`ifdef SB_RX_DISCONNECT_DET_EN
    localparam int DW = $clog2(DISC_CYCLES + 1);

    logic [DW-1:0] low_cnt;
    logic [3:0]    high_cnt;
    logic          disc_level;

    // disconnect drops on the first high cycle, but hunting stays held off for ten high cycles.
    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            low_cnt    <= '0;
            high_cnt   <= 4'd0;
            disc_level <= 1'b0;
            disc_hold  <= 1'b0;
        end else if (sbrx) begin
            low_cnt    <= '0;
            disc_level <= 1'b0;
            if (disc_hold) begin
                if (high_cnt == 4'd9) begin
                    disc_hold <= 1'b0;
                    high_cnt  <= 4'd0;
                end else begin
                    high_cnt <= high_cnt + 4'd1;
                end
            end
        end else begin
            high_cnt <= 4'd0;
            if (low_cnt != DW'(DISC_CYCLES))
                low_cnt <= low_cnt + DW'(1);
            if (low_cnt == DW'(DISC_CYCLES - 1)) begin
                disc_level <= 1'b1;
                disc_hold  <= 1'b1;
            end
        end
    end

    assign disconnect = disc_level;
`else
    assign disc_hold  = 1'b0;
    assign disconnect = 1'b0;
`endif

    assign hunt_en = enable && !disc_hold;

    sb_symbol_rx u_symbol_rx (
        .sb_clk    (sb_clk),
        .rst       (rst),
        .sbrx      (sbrx),
        .hunt_en   (hunt_en),
        .sym_byte  (sym_byte),
        .sym_valid (sym_valid),
        .sym_err   (sym_err)
    );

    // A destuffed DLE pair carries the value FE, which is the received symbol itself.
    assign data_take = sym_valid &&
                       (((state == F_DATA) && (sym_byte != SB_DLE)) ||
                        ((state == F_ESC)  && (sym_byte == SB_DLE)));

    always_ff @(posedge sb_clk or posedge rst) begin
        if (rst) begin
            state      <= F_IDLE;
            crc        <= CRC_SEED;
            buf0       <= 8'h00;
            buf1       <= 8'h00;
            buf2       <= 8'h00;
            buf_cnt    <= 2'd0;
            emit_cnt   <= '0;
            rx_byte    <= 8'h00;
            rx_valid   <= 1'b0;
            rx_first   <= 1'b0;
            rx_last    <= 1'b0;
            rx_stx     <= 8'h00;
            frame_done <= 1'b0;
            crc_err    <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_valid   <= 1'b0;
            rx_first   <= 1'b0;
            rx_last    <= 1'b0;
            frame_done <= 1'b0;
            crc_err    <= 1'b0;
            frame_err  <= 1'b0;

            if (!enable || disc_hold) begin
                state <= F_IDLE;
            end else if (sym_err) begin
                frame_err <= 1'b1;
                state     <= F_IDLE;
            end else if (sym_valid) begin
                case (state)
                    F_IDLE: begin
                        if (sym_byte == SB_DLE)
                            state <= F_WAIT_STX;
                    end
                    F_WAIT_STX: begin
                        if (sym_byte == SB_ETX) begin
                            frame_err <= 1'b1;
                            state     <= F_IDLE;
                        end else if (sym_byte != SB_DLE) begin
                            rx_stx   <= sym_byte;
                            crc      <= crc16_byte(CRC_SEED, sym_byte);
                            buf_cnt  <= 2'd0;
                            emit_cnt <= '0;
                            state    <= F_DATA;
                        end
                    end
                    F_DATA: begin
                        if (sym_byte == SB_DLE)
                            state <= F_ESC;
                    end
                    F_ESC: begin
                        if (sym_byte == SB_DLE) begin
                            state <= F_DATA;
                        end else if (sym_byte == SB_ETX) begin
                            state <= F_IDLE;
                            if ((buf_cnt != 2'd3) || (emit_cnt == EW'(MAX_BYTES))) begin
                                frame_err <= 1'b1;
                            end else begin
                                rx_valid <= 1'b1;
                                rx_byte  <= buf0;
                                rx_first <= (emit_cnt == '0);
                                rx_last  <= 1'b1;
                                if (crc == 16'h0000)
                                    frame_done <= 1'b1;
                                else
                                    crc_err <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            state     <= F_IDLE;
                        end
                    end
                    default: state <= F_IDLE;
                endcase

                // Three bytes stay buffered so the two CRC bytes are never emitted and rx_last can be tagged at ETX.
                if (data_take) begin
                    crc  <= crc16_byte(crc, sym_byte);
                    buf0 <= buf1;
                    buf1 <= buf2;
                    buf2 <= sym_byte;
                    if (buf_cnt != 2'd3) begin
                        buf_cnt <= buf_cnt + 2'd1;
                    end else if (emit_cnt == EW'(MAX_BYTES)) begin
                        frame_err <= 1'b1;
                        state     <= F_IDLE;
                    end else begin
                        rx_valid <= 1'b1;
                        rx_byte  <= buf0;
                        rx_first <= (emit_cnt == '0);
                        emit_cnt <= emit_cnt + EW'(1);
                    end
                end
            end
        end
    end

endmodule
